// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and its companion transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling state machine feeding a one-deep
// valid/ready output register with overrun and framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 rxd,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic                 w_rxd_s;
    uart_rx_state_t       r_state, w_state_nx;
    logic [CW-1:0]        r_cnt, w_cnt_nx;
    logic [2:0]           r_idx, w_idx_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 w_done;
    logic                 w_ferr;
    logic                 r_rx_valid;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_ferr;
    logic                 r_ovr;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .reset_ (reset_),
        .i_d    (rxd),
        .o_q    (w_rxd_s)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_done     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxd_s) begin
                    w_cnt_nx   = HALF_LD;
                    w_state_nx = START;
                end
            end
            START: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else if (!w_rxd_s) begin
                    w_cnt_nx   = FULL_LD;
                    w_idx_nx   = '0;
                    w_state_nx = DATA;
                end else begin
                    // Start bit was high at mid-bit: treat the edge as noise.
                    w_state_nx = IDLE;
                end
            end
            DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_shift_nx = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_nx   = FULL_LD;
                    if (r_idx == LAST_IDX) begin
                        w_state_nx = STOP;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else if (w_rxd_s) begin
                    // Leaving at mid-stop-bit leaves time to catch the next start edge.
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_ferr     = 1'b1;
                    w_state_nx = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (w_rxd_s) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;
            if (w_done) begin
                // A consumer accepting in the completion cycle frees the slot.
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_valid    = r_rx_valid;
    assign rx_data     = r_rx_data;
    assign framing_err = r_ferr;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 clocks per bit: directed scenarios plus
// randomized frames with baud mismatch, checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 8;
    localparam real CLK_NS = 10.0;

    logic       clk;
    logic       reset_;
    logic       rxd;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       framing_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    int  vrise_cnt = 0;
    int  vhigh_cnt = 0;
    int  ferr_cnt  = 0;
    int  ovr_cnt   = 0;
    time t_rise    = 0;
    time t_start   = 0;
    logic prev_valid = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .rxd         (rxd),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial line driver: start, 8 data bits LSB first, stop, optional low tail.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input real bitp, input int low_tail);
        @(negedge clk);
        rxd = 1'b0;
        t_start = $time;
        #(bitp);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bitp);
        end
        rxd = stop_bit;
        #(bitp);
        if (low_tail > 0) begin
            rxd = 1'b0;
            repeat (low_tail) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    // Monitor: sample mid-cycle, pop the scoreboard on every accepted byte.
    always begin
        @(negedge clk);
        #1;
        if (reset_) begin
            if (rx_valid && !prev_valid) begin
                vrise_cnt++;
                t_rise = $time - 1;
            end
            if (rx_valid) vhigh_cnt++;
            if (framing_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%02h with no byte expected", rx_data);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    if (rx_data !== exp_b) begin
                        errors++;
                        $display("FAIL rx_byte: got 0x%02h expected 0x%02h", rx_data, exp_b);
                    end
                end
            end
            prev_valid = rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        int vb, vh, fb, ob;
        logic [7:0] rb;
        real bitp;

        reset_   = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_framing_err", 32'(framing_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, latency and one-cycle valid pulse.
        rx_ready = 1'b1;
        vb = vrise_cnt; vh = vhigh_cnt; fb = ferr_cnt; ob = ovr_cnt;
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, CPB * CLK_NS, 0);
        repeat (10) @(negedge clk);
        chk("single_latency_cycles", 32'((t_rise - t_start) / 10), 32'd79);
        chk("single_valid_rises", 32'(vrise_cnt - vb), 32'd1);
        chk("single_valid_width", 32'(vhigh_cnt - vh), 32'd1);
        chk("single_no_ferr", 32'(ferr_cnt - fb), 32'd0);
        chk("single_no_ovr", 32'(ovr_cnt - ob), 32'd0);
        chk("single_drained", 32'(sb.size()), 32'd0);

        // Back-to-back with backpressure: second byte is dropped.
        rx_ready = 1'b0;
        ob = ovr_cnt;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, CPB * CLK_NS, 0);
        send_frame(8'h3C, 1'b1, CPB * CLK_NS, 0);
        repeat (6) @(negedge clk);
        #1;
        chk("bp_overrun_pulses", 32'(ovr_cnt - ob), 32'd1);
        chk("bp_data_held", 32'(rx_data), 32'hA5);
        chk("bp_valid_held", 32'(rx_valid), 32'd1);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_valid_drops", 32'(rx_valid), 32'd0);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Accept in the same cycle the second byte completes.
        @(negedge clk);
        rx_ready = 1'b0;
        ob = ovr_cnt;
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        send_frame(8'hA5, 1'b1, CPB * CLK_NS, 0);
        fork
            send_frame(8'h3C, 1'b1, CPB * CLK_NS, 0);
            begin
                @(negedge rxd);
                repeat (78) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                #1;
                chk("same_cycle_valid", 32'(rx_valid), 32'd1);
                chk("same_cycle_data", 32'(rx_data), 32'h3C);
            end
        join
        repeat (4) @(negedge clk);
        chk("same_cycle_no_ovr", 32'(ovr_cnt - ob), 32'd0);
        chk("same_cycle_drained", 32'(sb.size()), 32'd0);

        // Framing error followed by a held-low line, then recovery.
        vb = vrise_cnt; fb = ferr_cnt;
        send_frame(8'hFF, 1'b0, CPB * CLK_NS, 40);
        repeat (10) @(negedge clk);
        chk("ferr_pulses", 32'(ferr_cnt - fb), 32'd1);
        chk("ferr_no_valid", 32'(vrise_cnt - vb), 32'd0);
        sb.push_back(8'h01);
        send_frame(8'h01, 1'b1, CPB * CLK_NS, 0);
        repeat (10) @(negedge clk);
        chk("ferr_recover_valid", 32'(vrise_cnt - vb), 32'd1);
        chk("ferr_recover_drained", 32'(sb.size()), 32'd0);
        chk("ferr_no_extra", 32'(ferr_cnt - fb), 32'd1);

        // Two-cycle glitch on an idle line, then a normal frame.
        vb = vrise_cnt; fb = ferr_cnt;
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_valid", 32'(vrise_cnt - vb), 32'd0);
        chk("glitch_no_ferr", 32'(ferr_cnt - fb), 32'd0);
        rb = 8'($urandom);
        sb.push_back(rb);
        send_frame(rb, 1'b1, CPB * CLK_NS, 0);
        repeat (10) @(negedge clk);
        chk("glitch_then_byte", 32'(vrise_cnt - vb), 32'd1);

        // Reset in the middle of data bit 3 with a byte still held.
        rx_ready = 1'b0;
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, CPB * CLK_NS, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("pre_reset_valid", 32'(rx_valid), 32'd1);
        chk("pre_reset_data", 32'(rx_data), 32'h5A);
        fork
            send_frame(8'h96, 1'b1, CPB * CLK_NS, 0);
            begin
                @(negedge rxd);
                repeat (36) @(negedge clk);
                #3;
                reset_ = 1'b0;
                #1;
                chk("midreset_valid", 32'(rx_valid), 32'd0);
                chk("midreset_data", 32'(rx_data), 32'd0);
                chk("midreset_ferr", 32'(framing_err), 32'd0);
                chk("midreset_ovr", 32'(overrun), 32'd0);
            end
        join
        sb.delete();
        @(negedge clk);
        reset_   = 1'b1;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, CPB * CLK_NS, 0);
        repeat (10) @(negedge clk);
        chk("post_reset_drained", 32'(sb.size()), 32'd0);

        // Random bytes, random gaps, up to +/-2% baud mismatch.
        for (int n = 0; n < 24; n++) begin
            rb   = 8'($urandom);
            bitp = CPB * CLK_NS * (1.0 + real'(int'($urandom_range(400, 0)) - 200) / 10000.0);
            sb.push_back(rb);
            send_frame(rb, 1'b1, bitp, 0);
            repeat ($urandom_range(6, 0)) @(negedge clk);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("final_drained", 32'(sb.size()), 32'd0);
        chk("total_overruns", 32'(ovr_cnt), 32'd1);
        chk("total_framing_errs", 32'(ferr_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the design's UART transmitter. It deserialises 8N1 frames arriving on the serial RX line and presents each byte on a valid/ready output. It sits between the `uart_rxd` pad and on-chip consumers. Testbenches also instantiate it on `uart_txd` to check what the DUT sends.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per bit. 217 gives 115200 baud at 25 MHz. Legal range is 4 and above.
- `clk` input, 1 bit: single clock. Every flop in the block runs on it.
- `reset_` input, 1 bit: asynchronous, active-low reset.
- `rxd` input, 1 bit: serial line. Asynchronous to `clk`. Idle level is high.
- `rx_valid` output, 1 bit: `rx_data` holds an unconsumed byte.
- `rx_ready` input, 1 bit: the consumer accepts the byte this cycle.
- `rx_data` output, 8 bits: received byte, LSB is the first data bit on the line.
- `framing_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `overrun` output, 1 bit: one-cycle pulse when a byte is dropped because `rx_valid` is still held.

## Operation
**Input synchronisation**
- `rxd` passes through a 2-flop synchronizer. The output is `rxd_s`, which resets to 1.
- All receive logic uses `rxd_s` only.

**State machine: IDLE → START → DATA → STOP → IDLE, plus WAIT_HIGH**
- **IDLE:** when `rxd_s` is 0, load the bit counter with `CLKS_PER_BIT/2 - 1` (integer division) and go to START.
- **START:** when the counter reaches 0, sample `rxd_s`.
  - If the sample is 0, reload the counter with `CLKS_PER_BIT-1`, clear the bit index and go to DATA.
  - If the sample is 1, treat it as a glitch: go back to IDLE, with no output and no error.
- **DATA:** on each counter expiry, shift `rxd_s` into the shift register, LSB-first, and reload the counter. After bit index 7, go to STOP.
- **STOP:** on counter expiry, sample `rxd_s`.
  - Sample 1 (good stop bit): deliver the byte and go to IDLE. Returning at mid-stop-bit is intentional, so the next start edge is caught.
  - Sample 0: pulse `framing_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxd_s` is 1, then go to IDLE. This prevents a held-low line (break) from being decoded as a stream of 0x00 bytes.

**Delivery**
- If `rx_valid` is 0, or `rx_ready` is 1 in the same cycle, load `rx_data` and set `rx_valid`.
  - Completion and consumption in the same cycle: the old byte is consumed, the new byte is loaded and `rx_valid` stays 1. No overrun is flagged.
- If `rx_valid` is 1 and `rx_ready` is 0: the new byte is dropped, `overrun` pulses, and the old byte and `rx_valid` are unchanged.
- `rx_valid` clears on any cycle with `rx_ready` = 1 and no new byte being delivered.
- `rx_data` changes only on a load.
- `rx_ready` is ignored while `rx_valid` is 0.

**Arithmetic**
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide and counts down to 0.
- The bit index is 3 bits wide.
- There is no wrap-around beyond reload.

## Timing
- **Reset values:** `rx_valid`=0, `rx_data`=0x00, `framing_err`=0, `overrun`=0, state IDLE, synchronizer flops 1.
- **Reset mid-frame:** a reset assertion at any point returns all of the above immediately (asynchronously). The partial frame is lost. After reset release, reception resumes at the next falling edge.
- **Synchronizer:** 2 cycles of latency from `rxd` to `rxd_s`.
- **Cycle counts**, with cycle 0 being the first cycle where IDLE sees `rxd_s` = 0:
  - Start sample at cycle `CLKS_PER_BIT/2`.
  - Data bit k sampled at cycle `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
  - Stop sample at cycle `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
  - `rx_valid`, `framing_err` and `overrun` are registered and assert one cycle after the stop sample.
- **Back-to-back frames:** the next start edge may arrive as early as `CLKS_PER_BIT/2` cycles after the stop sample. It must be received correctly.
- **Clock tolerance:** frames must decode correctly with up to ±2% baud mismatch.

## Structure
- **Shared package `uart_pkg`:**
  - `DATA_BITS` = 8.
  - `uart_rx_state_t` enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - The package is shared with the transmitter.
- **Sub-module `sync_2ff`:** a generic 2-flop synchronizer with reset value parameter `RESET_VAL` = 1. Reusable for `button`.
- Everything else lives in `uart_rx` itself.

## Test plan
All scenarios use `CLKS_PER_BIT`=8.
- **Single byte:** send 0x55 with `rx_ready` held 1 → `rx_valid` pulses 1 cycle with `rx_data`=0x55, exactly 77 cycles after `rxd_s` falls. No errors.
- **Back-to-back with backpressure:** send 0xA5 then 0x3C back-to-back with `rx_ready`=0 → 0xA5 is held, `overrun` pulses once at the second frame's end, and `rx_data` stays 0xA5. Then assert `rx_ready` → `rx_valid` drops the next cycle.
- **Same-cycle accept and complete:** raise `rx_ready` on the exact cycle the second byte 0x3C completes → `rx_data`=0x3C, `rx_valid` stays 1, no `overrun`.
- **Framing error:** send 0xFF with the stop bit forced 0, then hold the line low for 40 cycles → `framing_err` pulses once, no `rx_valid`, no further bytes decoded. Then release the line and send 0x01 → 0x01 is received.
- **Glitch rejection:** a 2-cycle low glitch on an idle line → no `rx_valid` and no error; the state returns to IDLE.
- **Reset mid-frame:** assert `reset_` low during data bit 3 → all outputs are 0 immediately. Release reset and send 0xC3 → 0xC3 is received.
